controller_sequencer: RTL
=========================

Name: controller_sequencer

Overview:
SAP-1 control unit. A 6-state ring counter (T1..T6) combined with the instruction register opcode produces the 12-bit control word. Among its outputs it drives C_P and E_P into the program counter, L_M_bar into the MAR, and the enables and loads for the RAM, IR, A, ALU, B and output register. It also raises HLT on a halt instruction so the clock source can be stopped.

Parameters:
OP_W, 4, opcode width (upper nibble of the instruction register).
HALT_OP, 4'b1111, opcode that halts the machine.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
CLR  input  1  synchronous active-high reset.
opcode  input  OP_W  IR upper nibble; sampled combinationally during T4..T6 only.
T  output  6  one-hot ring state, T[0]=T1 .. T[5]=T6.
C_P  output  1  program counter count enable (active high).
E_P  output  1  program counter output enable (active high).
L_M_bar  output  1  MAR load (active low).
C_E_bar  output  1  RAM output enable (active low).
L_I_bar  output  1  IR load (active low).
E_I_bar  output  1  IR address-nibble output enable (active low).
L_A_bar  output  1  accumulator load (active low).
E_A  output  1  accumulator output enable.
S_U  output  1  ALU subtract select.
E_U  output  1  ALU output enable.
L_B_bar  output  1  B register load (active low).
L_O_bar  output  1  output register load (active low).
HLT  output  1  halt flag, sticky until CLR.

Behaviour:
- Reset: CLR is sampled on the rising CLK edge. On that edge: T=000001 and HLT=0. CLR overrides halt and any mid-instruction state.
- Ring advance: with CLR=0 and HLT=0, each edge rotates T1->T2->...->T6->T1.
- Control word: a pure decode of (T, opcode), with no register stage. It is valid in the same cycle the state is entered.
- Inactive levels: active-low signals =1, active-high signals =0, unless listed below.
- Fetch, independent of opcode:
  - T1: E_P=1, L_M_bar=0.
  - T2: C_P=1.
  - T3: C_E_bar=0, L_I_bar=0.
- LDA 0000:
  - T4: E_I_bar=0, L_M_bar=0.
  - T5: C_E_bar=0, L_A_bar=0.
  - T6: nop.
- ADD 0001:
  - T4: E_I_bar=0, L_M_bar=0.
  - T5: C_E_bar=0, L_B_bar=0.
  - T6: E_U=1, L_A_bar=0, S_U=0.
- SUB 0010: same as ADD, except S_U=1 during T6.
- OUT 1110:
  - T4: E_A=1, L_O_bar=0.
  - T5, T6: nop.
- HALT_OP:
  - In T4, HLT rises combinationally and is registered on that edge.
  - The ring then freezes at T4, with all control signals inactive while halted.
  - Only CLR exits the halt state.
- Any other opcode: T4..T6 are nops and the ring continues normally.
- Exclusivity: at most one bus driver is active per state (E_P, C_E_bar=0, E_I_bar=0, E_A, E_U). The verifier checks this every cycle.
- Illegal T: if T is not one-hot, the next edge forces T=000001. This is a recovery path only.
- Reset output values: T1 word, i.e. E_P=1, L_M_bar=0, all others inactive, HLT=0.

Test Plan:
- CLR=1 for 1 edge, opcode=0000, then run 12 cycles -> T sequence 1,2,4,8,16,32 repeats. Fetch words match: T1 E_P=1/L_M_bar=0, T2 C_P=1, T3 C_E_bar=0/L_I_bar=0.
- opcode=0001 (ADD) -> T5 L_B_bar=0/C_E_bar=0; T6 E_U=1, L_A_bar=0, S_U=0. With opcode=0010, T6 S_U=1 and otherwise identical.
- opcode=1110 (OUT) -> T4 E_A=1, L_O_bar=0; T5/T6 all inactive.
- opcode=1111 at T4 -> HLT=1 after the edge; T stays 001000 for 10 cycles with all controls inactive. Then CLR=1 -> T=000001, HLT=0.
- Assert CLR during T5 of a LDA -> next edge T=000001 with the T1 control word.
- Unknown opcode 0111 -> T4..T6 all inactive, no halt, ring wraps to T1. Bus-driver exclusivity holds across all tests.

Source files
------------

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring (T1..T6) decoded with the IR opcode
// into the control word, plus a sticky halt flag that freezes the ring at T4.
module controller_sequencer #(
  parameter int unsigned          OP_W    = 4,
  parameter logic [OP_W-1:0]      HALT_OP = OP_W'(4'b1111)
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [OP_W-1:0] opcode,
  output logic [5:0]      T,
  output logic            C_P,
  output logic            E_P,
  output logic            L_M_bar,
  output logic            C_E_bar,
  output logic            L_I_bar,
  output logic            E_I_bar,
  output logic            L_A_bar,
  output logic            E_A,
  output logic            S_U,
  output logic            E_U,
  output logic            L_B_bar,
  output logic            L_O_bar,
  output logic            HLT
);

  typedef enum logic [5:0] {
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_T3 = 6'b000100,
    S_T4 = 6'b001000,
    S_T5 = 6'b010000,
    S_T6 = 6'b100000
  } ring_e;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);

  ring_e state_q, state_d;
  logic  hlt_q, hlt_d;
  logic  halt_now;

  assign halt_now = !hlt_q && (state_q == S_T4) && (opcode == HALT_OP);
  assign hlt_d    = hlt_q | halt_now;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  // Any non-one-hot value falls to the default arm and recovers to T1.
  always_comb begin
    state_d = S_T1;
    if (hlt_q || halt_now) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = S_T4;
        S_T4:    state_d = S_T5;
        S_T5:    state_d = S_T6;
        S_T6:    state_d = S_T1;
        default: state_d = S_T1;
      endcase
    end
  end

  always_comb begin
    C_P     = 1'b0;
    E_P     = 1'b0;
    L_M_bar = 1'b1;
    C_E_bar = 1'b1;
    L_I_bar = 1'b1;
    E_I_bar = 1'b1;
    L_A_bar = 1'b1;
    E_A     = 1'b0;
    S_U     = 1'b0;
    E_U     = 1'b0;
    L_B_bar = 1'b1;
    L_O_bar = 1'b1;
    if (!hlt_q && !halt_now) begin
      case (state_q)
        S_T1: begin
          E_P     = 1'b1;
          L_M_bar = 1'b0;
        end
        S_T2: C_P = 1'b1;
        S_T3: begin
          C_E_bar = 1'b0;
          L_I_bar = 1'b0;
        end
        S_T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            E_I_bar = 1'b0;
            L_M_bar = 1'b0;
          end else if (opcode == OP_OUT) begin
            E_A     = 1'b1;
            L_O_bar = 1'b0;
          end
        end
        S_T5: begin
          if (opcode == OP_LDA) begin
            C_E_bar = 1'b0;
            L_A_bar = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            C_E_bar = 1'b0;
            L_B_bar = 1'b0;
          end
        end
        S_T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            E_U     = 1'b1;
            L_A_bar = 1'b0;
            S_U     = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign T   = state_q;
  assign HLT = hlt_d;

endmodule
